// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, Rcon seed, key-schedule states and
// the GF(2^8) doubling used by both key expansion and mix-columns.
package aes_pkg;

   localparam int         AES_NR    = 10;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      IDLE,
      OUT,
      GEN
   } ks_state_t;

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
   input  logic [7:0] b,
   output logic [7:0] s
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign s = SBOX[b];

endmodule

// File: rtl/aes_key_sched_seq.sv
// Iterative AES-128 key expansion: emits RK0..RK10 over a valid/ready
// handshake, computing each next round key in a single GEN cycle.
module aes_key_sched_seq
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [0:127] i_key,
   input  logic         i_start,
   output logic         o_busy,
   output logic [0:127] o_rkey,
   output logic [3:0]   o_round,
   output logic         o_valid,
   input  logic         i_ready,
   output logic         o_done
);

   ks_state_t     state;
   logic [7:0]    rcon;
   logic [31:0]   w0, w1, w2, w3;
   logic [31:0]   rot, sub;
   logic [31:0]   w4, w5, w6, w7;
   logic [127:0]  next_key;

   assign w0 = o_rkey[0:31];
   assign w1 = o_rkey[32:63];
   assign w2 = o_rkey[64:95];
   assign w3 = o_rkey[96:127];

   // RotWord then SubWord through four shared S-box instances.
   assign rot = {w3[23:0], w3[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_subword
      aes_sbox u_sbox (
         .b (rot[8*g +: 8]),
         .s (sub[8*g +: 8])
      );
   end

   assign w4       = w0 ^ sub ^ {rcon, 24'h0};
   assign w5       = w1 ^ w4;
   assign w6       = w2 ^ w5;
   assign w7       = w3 ^ w6;
   assign next_key = {w4, w5, w6, w7};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         o_busy  <= 1'b0;
         o_valid <= 1'b0;
         o_done  <= 1'b0;
         o_round <= 4'd0;
         o_rkey  <= '0;
         rcon    <= RCON_INIT;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  o_rkey  <= i_key;
                  o_round <= 4'd0;
                  rcon    <= RCON_INIT;
                  o_valid <= 1'b1;
                  o_busy  <= 1'b1;
                  state   <= OUT;
               end
            end
            OUT: begin
               // Key and round stay frozen until the consumer takes them.
               if (i_ready) begin
                  o_valid <= 1'b0;
                  if (o_round == 4'(NR)) begin
                     o_busy <= 1'b0;
                     o_done <= 1'b1;
                     state  <= IDLE;
                  end else begin
                     state <= GEN;
                  end
               end
            end
            GEN: begin
               o_rkey  <= next_key;
               o_round <= o_round + 4'd1;
               rcon    <= xtime(rcon);
               o_valid <= 1'b1;
               state   <= OUT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/aes_key_sched_seq.md
Name: aes_key_sched_seq

Overview:
- Iterative AES-128 key-expansion engine.
- Produces round keys RK0..RK10 one per handshake for the add-round-key stage that consumes the mix-column output of each round.
- Computes one round key per cycle from the previous one, using a shared 4-byte S-box and an Rcon register advanced by GF(2^8) xtime.
- Decouples key scheduling from the datapath with a valid/ready interface so the round datapath can stall it.

Parameters:
- NR, 10, number of rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- i_key  in  [0:127]  cipher key; bit 0 is the MSB of byte 0 (FIPS-197 byte order)
- i_start  in  1  request new expansion; sampled only when o_busy=0
- o_busy  out  1  expansion in progress
- o_rkey  out  [0:127]  current round key, same byte order as i_key
- o_round  out  4  index of o_rkey, 0..10
- o_valid  out  1  o_rkey/o_round valid
- i_ready  in  1  consumer accepts o_rkey when o_valid and i_ready are both high
- o_done  out  1  single-cycle pulse the cycle after RK10 is accepted

Behaviour:
- Reset, sampled with rst_n=0 at a clk edge:
  - state IDLE; o_busy=0, o_valid=0, o_done=0, o_round=0, o_rkey=0, rcon=8'h01.
  - Reset mid-expansion aborts immediately; no o_done is produced.
- States:
  - IDLE: o_valid=0. i_start=1 latches i_key into the key register, clears o_round to 0, loads rcon=8'h01, then goes to OUT.
  - OUT: o_valid=1, o_busy=1. o_rkey and o_round are held stable until the handshake.
    - On handshake with o_round<10: go to GEN.
    - On handshake with o_round=10: go to IDLE, and o_done=1 for exactly that next cycle.
  - GEN (one cycle): o_valid=0.
    - Compute the next key: w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6.
    - w0..w3 are the 32-bit words of o_rkey, w0 at bits [0:31].
    - Register the new key, increment o_round, set rcon = xtime(rcon) (shift left, ^8'h1b if MSB set), return to OUT.
- Latency:
  - i_start at edge t gives RK0 valid at t+1.
  - Each subsequent key becomes valid 2 cycles after the accepting edge of the previous one.
  - With i_ready tied high, 21 cycles from i_start to the o_done pulse.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36; it must wrap 80→1b through xtime.
- Handshake rules:
  - o_valid never drops without acceptance.
  - i_ready is ignored while o_valid=0.
  - i_ready may be high before o_valid.
- i_start while o_busy=1 is ignored; no restart and no change to the key register.
- i_start asserted in the same cycle as the o_done pulse (state IDLE) is accepted normally.
- i_key changes after the start cycle have no effect on the current expansion.
- o_busy=1 from the cycle after start through the RK10 accept edge; it is 0 in IDLE.

Decomposition:
- Shared package aes_pkg holds:
  - constant AES_NR=10
  - function xtime (8-bit GF(2^8) doubling)
  - RCON_INIT=8'h01
  - a state enum for IDLE/OUT/GEN
- xtime must be the same definition used by the mix-column stage.
- One sub-module, aes_sbox: combinational 8-bit forward S-box. Instantiate it 4× for SubWord.
- The FSM, key register and rcon stay in aes_key_sched_seq.

Test Plan:
- Reset, then i_key=2b7e151628aed2a6abf7158809cf4f3c, i_start pulse, i_ready=1:
  - RK0 equals the key at round 0.
  - RK1=a0fafe1788542cb123a339392a6c7605.
  - RK10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - o_done 21 cycles after start.
- i_key=0, i_ready=1:
  - RK1=62636363626363636263636362636363.
  - RK10=b4ef5bcb3e92e21123e951cf6f8f188e.
  - Internal rcon shows 80→1b→36 across rounds 8-10.
- Same key as the first scenario, i_ready randomly low 50%:
  - o_rkey/o_round stable while o_valid && !i_ready.
  - Same 11 keys in order, no skips or duplicates.
- i_start re-pulsed with a different i_key during round 4: ignored; the sequence completes with the original key's RK10.
- rst_n=0 for one cycle during round 6:
  - All outputs 0 next cycle, no o_done.
  - A new start afterwards yields a correct RK1 for the new key.
- Back-to-back: i_start held high through the o_done cycle → a second expansion starts immediately and RK0 is valid the cycle after.
